me_exp_core: RTL
================

Name: me_exp_core

Overview:
Parametrised successor of the fixed-key modular exponentiator in the RSA block. It computes res = x^e mod m using left-to-right square-and-multiply over one internal mm_r2mm_2n Montgomery multiplier. The modulus and the Montgomery constants are run-time inputs, not hard-wired values. The exponent width is independent of K, leading zero bits of e are skipped, and an abort input is provided. It sits between the RSA bus wrapper and mm_r2mm_2n.

Parameters:
K, 2048, operand/modulus width; even, <8191.
EW, K, exponent width; 1..K.
CW, 16, width of the multiplication counter mm_cnt.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  cancel current operation; ignored in IDLE
x  in  K  base; precondition x < m
e  in  EW  exponent
m  in  K  modulus; precondition odd, 1 < m < 2^K
r2  in  K  2^(2K) mod m
r1  in  K  2^K mod m (Montgomery one)
busy  out  1  high from the cycle after an accepted start until the return to IDLE
res  out  K  result; holds until the next accepted start
res_valid  out  1  one-cycle pulse when res is updated
aborted  out  1  one-cycle pulse when an abort completes
mm_cnt  out  CW  number of mm_r2mm_2n requests in the last or current operation; saturates at all-ones

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the multiplier req is 0. Reset mid-operation discards everything; no pulse is emitted afterwards.
- On start in IDLE: latch x, e, m, r2, r1 into internal registers. Inputs may change afterwards. Clear res and mm_cnt, set busy, go to SCAN.
- SCAN:
  - Shift e left one bit per cycle while MSB==0 and remaining bits > 0.
  - If all EW bits are 0 (e==0): set acc=r1, go to FROMM.
  - Otherwise consume the leading 1 and go to TOMONT.
- TOMONT: issue mm(x, r2). On val: acc = xm = res_mm. If no bits remain, go to FROMM; else go to SQR.
- SQR: issue mm(acc, acc). On val: acc updated. If the current bit is 1, go to MUL; else consume the bit and either go to SQR, or to FROMM if no bits remain.
- MUL: issue mm(acc, xm). On val: consume the bit, then go to SQR, or to FROMM if no bits remain.
- FROMM: issue mm(acc, 1). On val: res = res_mm, res_valid pulse, clear busy, go to IDLE.
- Multiplier handshake:
  - req is a single-cycle pulse issued in the cycle after the state entry.
  - Operands are held stable until val.
  - Only one request is outstanding at a time.
  - Every req increments mm_cnt.
  - Multiplier latency is variable; the block waits on val only, never on a fixed count.
- Request count:
  - e==0: 1 request (FROMM only).
  - Otherwise, for bit length L and popcount P of e: L+P requests.
- Abort while busy:
  - If no multiplier request is outstanding: go to IDLE next cycle.
  - Else go to DRAIN, wait for val, discard the result, then go to IDLE.
  - On entering IDLE: aborted pulses, busy clears, res remains 0, res_valid is not pulsed.
  - abort in the same cycle as val in FROMM: abort wins, no res_valid.
- start while busy is ignored. A start in the same cycle as the return to IDLE is ignored; start is accepted only in IDLE.
- abort and start together in IDLE: start is accepted.
- mm_cnt stays valid after completion until the next accepted start.

Test Plan:
- K=8, EW=8, m=239, r1=17, r2=50, x=5, e=3 -> res=125, res_valid pulses once, mm_cnt=4, busy low afterwards.
- Same constants, x=2, e=0x80 -> res=34, mm_cnt=9 (leading-zero skip of 0 bits, 7 squares).
- Same constants, x=2, e=0xFF -> res=100, mm_cnt=16. Same constants, x=7, e=0 -> res=1, mm_cnt=1.
- Abort 3 cycles after req in SQR -> DRAIN until val, then aborted pulse, res_valid never asserted, res=0. A following start with x=5, e=3 returns 125.
- Start pulse with different inputs mid-operation, and inputs changed after start -> ignored; first operation completes with the original result.
- rst_n asserted mid-MUL -> all outputs 0 immediately, no later pulses. K=2048 random vectors checked against a software modexp reference model.

Source files
------------

// File: rtl/me_exp_core.sv
// Modular exponentiator res = x^e mod m: left-to-right square-and-multiply over one
// radix-2 Montgomery multiplier (R = 2^K), with run-time modulus/constants and abort.

module mm_r2mm_2n #(
  parameter int unsigned K = 2048
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic [K-1:0] m,
  output logic         val,
  output logic [K-1:0] res
);
  localparam int unsigned NW = (K > 1) ? $clog2(K) : 1;

  logic [NW-1:0] cnt;
  logic          run;
  logic          fin;
  logic [K:0]    s;
  logic [K+1:0]  t;
  logic [K:0]    s_nxt;

  // One bit of a per cycle: s = (s + a_i*b + q*m) / 2, s stays below 2m.
  always_comb begin
    t = {1'b0, s} + (a[cnt] ? {2'b00, b} : (K+2)'(0));
    if (t[0]) t = t + {2'b00, m};
    s_nxt = t[K+1:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      run <= 1'b0;
      fin <= 1'b0;
      s   <= '0;
      val <= 1'b0;
      res <= '0;
    end else begin
      val <= 1'b0;
      fin <= 1'b0;
      if (req) begin
        s   <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        s   <= s_nxt;
        cnt <= cnt + NW'(1);
        if (cnt == NW'(K - 1)) begin
          run <= 1'b0;
          fin <= 1'b1;
        end
      end
      if (fin) begin
        val <= 1'b1;
        res <= (s >= {1'b0, m}) ? K'(s - {1'b0, m}) : s[K-1:0];
      end
    end
  end
endmodule

module me_exp_core #(
  parameter int unsigned K  = 2048,
  parameter int unsigned EW = K,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [K-1:0]  x,
  input  logic [EW-1:0] e,
  input  logic [K-1:0]  m,
  input  logic [K-1:0]  r2,
  input  logic [K-1:0]  r1,
  output logic          busy,
  output logic          res_valid,
  output logic [K-1:0]  res,
  output logic          aborted,
  output logic [CW-1:0] mm_cnt
);
  localparam int unsigned RW = $clog2(EW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_TOMONT, S_SQR, S_MUL, S_FROMM, S_DRAIN
  } state_t;

  state_t        state, state_d;
  logic [K-1:0]  x_q, x_d, m_q, m_d, r2_q, r2_d, r1_q, r1_d;
  logic [K-1:0]  acc_q, acc_d, xm_q, xm_d, op_a_q, op_a_d, op_b_q, op_b_d;
  logic [EW-1:0] e_q, e_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          req_q, req_d, issued_q, issued_d;
  logic          busy_d, res_valid_d, aborted_d;
  logic [K-1:0]  res_d;
  logic [CW-1:0] mm_cnt_d;
  logic          mm_val;
  logic [K-1:0]  mm_res;

  mm_r2mm_2n #(.K(K)) u_mm (
    .clk(clk), .rst_n(rst_n), .req(req_q), .a(op_a_q), .b(op_b_q), .m(m_q),
    .val(mm_val), .res(mm_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      x_q <= '0; m_q <= '0; r2_q <= '0; r1_q <= '0;
      acc_q <= '0; xm_q <= '0; op_a_q <= '0; op_b_q <= '0;
      e_q <= '0; rem_q <= '0; req_q <= 1'b0; issued_q <= 1'b0;
      busy <= 1'b0; res <= '0; res_valid <= 1'b0; aborted <= 1'b0; mm_cnt <= '0;
    end else begin
      state <= state_d;
      x_q <= x_d; m_q <= m_d; r2_q <= r2_d; r1_q <= r1_d;
      acc_q <= acc_d; xm_q <= xm_d; op_a_q <= op_a_d; op_b_q <= op_b_d;
      e_q <= e_d; rem_q <= rem_d; req_q <= req_d; issued_q <= issued_d;
      busy <= busy_d; res <= res_d; res_valid <= res_valid_d; aborted <= aborted_d;
      mm_cnt <= mm_cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    x_d = x_q; m_d = m_q; r2_d = r2_q; r1_d = r1_q;
    acc_d = acc_q; xm_d = xm_q; op_a_d = op_a_q; op_b_d = op_b_q;
    e_d = e_q; rem_d = rem_q; req_d = 1'b0; issued_d = issued_q;
    busy_d = busy; res_d = res; res_valid_d = 1'b0; aborted_d = 1'b0;
    mm_cnt_d = mm_cnt;

    case (state)
      S_IDLE: if (start) begin
        x_d = x; m_d = m; r2_d = r2; r1_d = r1; e_d = e;
        rem_d = RW'(EW);
        res_d = '0; mm_cnt_d = '0; busy_d = 1'b1;
        state_d = S_SCAN;
      end
      // e_q[EW-1] is always the next exponent bit; rem_q counts bits not yet consumed.
      S_SCAN: begin
        if (rem_q == '0) begin
          acc_d = r1_q;
          state_d = S_FROMM;
        end else begin
          e_d = e_q << 1;
          rem_d = rem_q - RW'(1);
          if (e_q[EW-1]) state_d = S_TOMONT;
        end
      end
      S_TOMONT: if (mm_val) begin
        acc_d = mm_res; xm_d = mm_res; issued_d = 1'b0;
        state_d = (rem_q == '0) ? S_FROMM : S_SQR;
      end
      S_SQR: if (mm_val) begin
        acc_d = mm_res; issued_d = 1'b0;
        if (e_q[EW-1]) begin
          state_d = S_MUL;
        end else begin
          e_d = e_q << 1;
          rem_d = rem_q - RW'(1);
          state_d = (rem_q == RW'(1)) ? S_FROMM : S_SQR;
        end
      end
      S_MUL: if (mm_val) begin
        acc_d = mm_res; issued_d = 1'b0;
        e_d = e_q << 1;
        rem_d = rem_q - RW'(1);
        state_d = (rem_q == RW'(1)) ? S_FROMM : S_SQR;
      end
      S_FROMM: if (mm_val) begin
        res_d = mm_res; res_valid_d = 1'b1; busy_d = 1'b0; issued_d = 1'b0;
        state_d = S_IDLE;
      end
      S_DRAIN: if (mm_val) begin
        aborted_d = 1'b1; busy_d = 1'b0; issued_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // One request per multiply state, issued in its first cycle.
    if ((state inside {S_TOMONT, S_SQR, S_MUL, S_FROMM}) && !issued_q) begin
      req_d = 1'b1;
      issued_d = 1'b1;
      if (mm_cnt != '1) mm_cnt_d = mm_cnt + CW'(1);
      case (state)
        S_TOMONT: begin op_a_d = x_q;   op_b_d = r2_q;  end
        S_SQR:    begin op_a_d = acc_q; op_b_d = acc_q; end
        S_MUL:    begin op_a_d = acc_q; op_b_d = xm_q;  end
        default:  begin op_a_d = acc_q; op_b_d = K'(1); end
      endcase
    end

    // Abort overrides everything, including a result arriving this cycle.
    if (abort && state != S_IDLE && state != S_DRAIN) begin
      if (!issued_q || mm_val) begin
        state_d = S_IDLE; aborted_d = 1'b1; busy_d = 1'b0; issued_d = 1'b0;
        req_d = 1'b0; res_d = res; res_valid_d = 1'b0; mm_cnt_d = mm_cnt;
      end else begin
        state_d = S_DRAIN;
      end
    end
  end
endmodule
